// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out serializer.
//   DefaultWidth : default word width in bits
//   state_e      : FSM state encoding (StIdle = 1'b0, StShift = 1'b1)
package piso_pkg;

   localparam int unsigned DefaultWidth = 8;

   typedef enum logic {
      StIdle  = 1'b0,
      StShift = 1'b1
   } state_e;

endpackage

// File: rtl/bit_counter.sv
// Frame bit counter for the serializer.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, forces count to zero
//   clear  : synchronous clear to zero (start of frame)
//   enable : advance count by one
//   tc     : terminal count, high while count == WIDTH-1
module bit_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CntW-1:0] cnt_q;

   assign tc = (cnt_q == CntW'(WIDTH - 1));

   // Holding at terminal count keeps the counter from wrapping inside a frame.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (enable && !tc) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready load handshake.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   load_data  : parallel word to serialize
//   load_valid : load_data valid this cycle
//   load_ready : block can accept a word (high in IDLE)
//   bit_en     : shift strobe, one strobe consumes one bit
//   sdata      : registered serial data
//   sframe     : high while sdata carries a frame bit
//   done       : one-cycle pulse after the last bit is consumed
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter int unsigned MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] load_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             bit_en,
   output logic             sdata,
   output logic             sframe,
   output logic             done
);

   if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
      $error("piso_serializer: WIDTH must be in 2..32");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             sdata_q, sdata_d;
   logic             sframe_q, sframe_d;
   logic             done_q, done_d;
   logic             cnt_clear;
   logic             cnt_en;
   logic             cnt_tc;

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .tc     (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      sdata_d   = sdata_q;
      sframe_d  = sframe_q;
      done_d    = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         StIdle: begin
            sdata_d  = 1'b0;
            sframe_d = 1'b0;
            if (load_valid) begin
               shreg_d   = load_data;
               cnt_clear = 1'b1;
               state_d   = StShift;
               sframe_d  = 1'b1;
               sdata_d   = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
            end
         end
         StShift: begin
            if (bit_en) begin
               if (cnt_tc) begin
                  state_d  = StIdle;
                  sframe_d = 1'b0;
                  sdata_d  = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  cnt_en  = 1'b1;
                  shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                  // sdata is taken from the shifted word so it stays a plain register.
                  sdata_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         shreg_q  <= '0;
         sdata_q  <= 1'b0;
         sframe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         sdata_q  <= sdata_d;
         sframe_q <= sframe_d;
         done_q   <= done_d;
      end
   end

   assign load_ready = (state_q == StIdle);
   assign sdata      = sdata_q;
   assign sframe     = sframe_q;
   assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] a_load_data, b_load_data;
   logic       a_load_valid, b_load_valid;
   logic       a_load_ready, b_load_ready;
   logic       a_bit_en, b_bit_en;
   logic       a_sdata, b_sdata;
   logic       a_sframe, b_sframe;
   logic       a_done, b_done;

   int tests = 0;
   int fails = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   logic qa[$];
   logic qb[$];
   logic exp_a, exp_b;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst), .load_data(a_load_data), .load_valid(a_load_valid),
      .load_ready(a_load_ready), .bit_en(a_bit_en), .sdata(a_sdata), .sframe(a_sframe),
      .done(a_done)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst(rst), .load_data(b_load_data), .load_valid(b_load_valid),
      .load_ready(b_load_ready), .bit_en(b_bit_en), .sdata(b_sdata), .sframe(b_sframe),
      .done(b_done)
   );

   // Scoreboard monitors: a frame bit is consumed when sframe and bit_en are both high.
   always @(negedge clk) begin
      if (!rst && a_sframe === 1'b1 && a_bit_en === 1'b1) begin
         tests++;
         if (qa.size() == 0) begin
            fails++;
            $display("FAIL a_unexpected_bit: sdata=%0b, required no frame bit", a_sdata);
         end else begin
            exp_a = qa.pop_front();
            if (a_sdata !== exp_a) begin
               fails++;
               $display("FAIL a_bit: sdata=%0b, required %0b", a_sdata, exp_a);
            end
         end
      end
      if (!rst && b_sframe === 1'b1 && b_bit_en === 1'b1) begin
         tests++;
         if (qb.size() == 0) begin
            fails++;
            $display("FAIL b_unexpected_bit: sdata=%0b, required no frame bit", b_sdata);
         end else begin
            exp_b = qb.pop_front();
            if (b_sdata !== exp_b) begin
               fails++;
               $display("FAIL b_bit: sdata=%0b, required %0b", b_sdata, exp_b);
            end
         end
      end
      if (a_done === 1'b1) done_cnt_a++;
      if (b_done === 1'b1) done_cnt_b++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) qa.push_back(d[i]);
   endtask

   task automatic push_b(input logic [7:0] d);
      for (int i = 0; i < 8; i++) qb.push_back(d[i]);
   endtask

   task automatic chk(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0b, required %0b", name, act, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_load_valid = 1'b1; a_load_data = 8'hFF; a_bit_en = 1'b1;
      b_load_valid = 1'b1; b_load_data = 8'hFF; b_bit_en = 1'b1;
      tick();
      tick();
      tests++;
      if ({a_sframe, a_sdata, a_done, a_load_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_a: got %b, required 0001", {a_sframe, a_sdata, a_done, a_load_ready});
      end
      tests++;
      if ({b_sframe, b_sdata, b_done, b_load_ready} !== 4'b0001) begin
         fails++;
         $display("FAIL reset_b: got %b, required 0001", {b_sframe, b_sdata, b_done, b_load_ready});
      end
      rst = 1'b0;
      a_load_valid = 1'b0; a_bit_en = 1'b0;
      b_load_valid = 1'b0; b_bit_en = 1'b0;
      tick();
      tests++;
      if (a_load_ready !== 1'b1 || a_sframe !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: load_ready=%0b sframe=%0b, required 1 0",
                  a_load_ready, a_sframe);
      end
   endtask

   // Full frame on dut_a with bit_en every cycle.
   task automatic run_frame_a(input logic [7:0] d);
      int d0;
      d0 = done_cnt_a;
      push_a(d);
      a_load_data = d; a_load_valid = 1'b1; a_bit_en = 1'b0;
      tick();
      a_load_valid = 1'b0;
      a_load_data = ~d;
      chk("first_sframe", a_sframe, 1'b1);
      chk("first_sdata", a_sdata, d[7]);
      chk("shift_load_ready", a_load_ready, 1'b0);
      a_bit_en = 1'b1;
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("frame_sframe", a_sframe, 1'b1);
      end
      tick();
      chk("done_pulse", a_done, 1'b1);
      chk("done_sframe", a_sframe, 1'b0);
      chk("done_sdata", a_sdata, 1'b0);
      chk("done_load_ready", a_load_ready, 1'b1);
      a_bit_en = 1'b0;
      tick();
      chk("done_one_cycle", a_done, 1'b0);
      tests++;
      if (done_cnt_a - d0 != 1) begin
         fails++;
         $display("FAIL done_count: got %0d pulses, required 1", done_cnt_a - d0);
      end
      tests++;
      if (qa.size() != 0) begin
         fails++;
         $display("FAIL frame_bits_a: %0d bits not emitted, required 0", qa.size());
      end
   endtask

   task automatic test_msb_a5();
      run_frame_a(8'hA5);
   endtask

   task automatic test_lsb_sparse();
      logic [7:0] d;
      int         d0;
      d = 8'h01;
      d0 = done_cnt_b;
      push_b(d);
      b_load_data = d; b_load_valid = 1'b1; b_bit_en = 1'b0;
      tick();
      b_load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 3; k++) begin
            chk("lsb_sframe", b_sframe, 1'b1);
            chk("lsb_hold", b_sdata, d[i]);
            b_bit_en = (k == 2);
            tick();
         end
      end
      b_bit_en = 1'b0;
      chk("lsb_done", b_done, 1'b1);
      chk("lsb_done_sframe", b_sframe, 1'b0);
      tick();
      tests++;
      if (done_cnt_b - d0 != 1 || qb.size() != 0) begin
         fails++;
         $display("FAIL lsb_frame: done pulses %0d left %0d, required 1 0",
                  done_cnt_b - d0, qb.size());
      end
   endtask

   task automatic test_back_to_back();
      push_a(8'hFF);
      a_load_data = 8'hFF; a_load_valid = 1'b1; a_bit_en = 1'b1;
      tick();
      a_load_valid = 1'b0;
      for (int t = 1; t <= 17; t++) begin
         tick();
         chk("b2b_sframe", a_sframe, !(t == 8 || t == 17));
         chk("b2b_done", a_done, (t == 8 || t == 17));
         if (t == 8) begin
            chk("b2b_ready_in_done", a_load_ready, 1'b1);
            push_a(8'h00);
            a_load_data = 8'h00; a_load_valid = 1'b1;
         end
         if (t == 9) begin
            a_load_valid = 1'b0;
            a_load_data = 8'h3C;
         end
      end
      a_bit_en = 1'b0;
      tick();
      tests++;
      if (qa.size() != 0) begin
         fails++;
         $display("FAIL b2b_bits: %0d bits not emitted, required 0", qa.size());
      end
   endtask

   task automatic test_load_during_shift();
      push_a(8'hC3);
      a_load_data = 8'hC3; a_load_valid = 1'b1; a_bit_en = 1'b1;
      tick();
      a_load_data = 8'h3C;
      for (int t = 1; t <= 8; t++) begin
         if (t < 8) chk("busy_load_ready", a_load_ready, 1'b0);
         if (t == 7) a_load_valid = 1'b0;
         tick();
      end
      chk("busy_done", a_done, 1'b1);
      a_bit_en = 1'b0;
      tick();
      chk("busy_not_queued", a_sframe, 1'b0);
      tests++;
      if (qa.size() != 0) begin
         fails++;
         $display("FAIL busy_bits: %0d bits not emitted, required 0", qa.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      int d0;
      push_a(8'hF0);
      a_load_data = 8'hF0; a_load_valid = 1'b1; a_bit_en = 1'b0;
      tick();
      a_load_valid = 1'b0;
      a_bit_en = 1'b1;
      repeat (4) tick();
      rst = 1'b1;
      qa.delete();
      d0 = done_cnt_a;
      tick();
      chk("abort_sframe", a_sframe, 1'b0);
      chk("abort_sdata", a_sdata, 1'b0);
      chk("abort_done", a_done, 1'b0);
      chk("abort_ready", a_load_ready, 1'b1);
      rst = 1'b0;
      a_bit_en = 1'b0;
      repeat (3) tick();
      tests++;
      if (done_cnt_a != d0) begin
         fails++;
         $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt_a - d0);
      end
      run_frame_a(8'h81);
   endtask

   task automatic test_idle_bit_en();
      a_load_valid = 1'b0;
      a_bit_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if ({a_sdata, a_sframe, a_done, a_load_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL idle_bit_en: got %b, required 0001",
                     {a_sdata, a_sframe, a_done, a_load_ready});
         end
      end
      a_bit_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_load_data = '0; a_load_valid = 1'b0; a_bit_en = 1'b0;
      b_load_data = '0; b_load_valid = 1'b0; b_bit_en = 1'b0;
      test_reset();
      test_msb_a5();
      test_lsb_sparse();
      test_back_to_back();
      test_load_during_shift();
      test_reset_mid_frame();
      test_idle_bit_en();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
